// File: rtl/compositor_pkg.sv
// Shared constants and types for the layer compositor.
// The layer index constants give the sprite generators a fixed stacking order.
package compositor_pkg;

    localparam int COLOR_W = 24;
    localparam logic [COLOR_W-1:0] DEFAULT_BG_COLOR = 24'h000000;

    localparam int LAYER_PLAYER = 0;
    localparam int LAYER_BULLET = 1;
    localparam int LAYER_ENEMY  = 2;
    localparam int LAYER_SHIELD = 3;

    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
    } sync_t;

    // Syncs are active-low, so the idle value holds them high.
    localparam sync_t SYNC_IDLE = '{active: 1'b0, hsync: 1'b1, vsync: 1'b1};

endpackage

// File: rtl/layer_compositor_if.sv
// Bus between the sprite generators / VGA driver and the compositor.
// The slave side is the compositor, the master side drives the layers and syncs.
interface layer_compositor_if #(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 24
);
    logic                          pix_en;
    logic [NUM_LAYERS*COLOR_W-1:0] layer_color;
    logic [NUM_LAYERS-1:0]         layer_valid;
    logic                          active_in;
    logic                          hsync_in;
    logic                          vsync_in;
    logic                          frame_done_in;
    logic [COLOR_W-1:0]            vga_color;
    logic                          active_out;
    logic                          hsync_out;
    logic                          vsync_out;
    logic [NUM_LAYERS-1:0]         collide_mask;
    logic                          collide_valid;

    modport slave (
        input  pix_en, layer_color, layer_valid, active_in, hsync_in, vsync_in, frame_done_in,
        output vga_color, active_out, hsync_out, vsync_out, collide_mask, collide_valid
    );

    modport master (
        output pix_en, layer_color, layer_valid, active_in, hsync_in, vsync_in, frame_done_in,
        input  vga_color, active_out, hsync_out, vsync_out, collide_mask, collide_valid
    );

endinterface

// File: rtl/layer_compositor_priority_mux.sv
// Combinational fixed-priority select: the lowest-index valid layer wins.
// hit is 0 when no layer is valid, letting the caller substitute the background.
module priority_mux #(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 24
) (
    input  logic [NUM_LAYERS*COLOR_W-1:0] colors,
    input  logic [NUM_LAYERS-1:0]         valids,
    output logic [COLOR_W-1:0]            color,
    output logic                          hit
);

    // Scan from the highest index down so the last assignment is the top layer.
    always_comb begin
        color = '0;
        hit   = 1'b0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (valids[i]) begin
                color = colors[i*COLOR_W +: COLOR_W];
                hit   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// Two-stage pixel compositor with sync delay matching and an optional
// per-frame overlap accumulator enabled by LAYER_COMPOSITOR_COLLIDE_EN.
module layer_compositor #(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = compositor_pkg::COLOR_W,
    parameter logic [COLOR_W-1:0] BG_COLOR = compositor_pkg::DEFAULT_BG_COLOR
) (
    input logic               clk,
    input logic               rst,
    layer_compositor_if.slave bus
);
    import compositor_pkg::*;

    logic [NUM_LAYERS*COLOR_W-1:0] s1_color;
    logic [NUM_LAYERS-1:0]         s1_valid;
    sync_t                         s1_sync;
    logic [COLOR_W-1:0]            s2_color;
    sync_t                         s2_sync;
    logic [COLOR_W-1:0]            sel_color;
    logic                          sel_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_color <= '0;
            s1_valid <= '0;
            s1_sync  <= SYNC_IDLE;
        end else if (bus.pix_en) begin
            s1_color <= bus.layer_color;
            s1_valid <= bus.layer_valid;
            s1_sync  <= '{active: bus.active_in, hsync: bus.hsync_in, vsync: bus.vsync_in};
        end
    end

    priority_mux #(
        .NUM_LAYERS (NUM_LAYERS),
        .COLOR_W    (COLOR_W)
    ) u_priority_mux (
        .colors (s1_color),
        .valids (s1_valid),
        .color  (sel_color),
        .hit    (sel_hit)
    );

    // Blanking is applied here so colour and active_out leave in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_color <= '0;
            s2_sync  <= SYNC_IDLE;
        end else if (bus.pix_en) begin
            if (!s1_sync.active)
                s2_color <= '0;
            else if (sel_hit)
                s2_color <= sel_color;
            else
                s2_color <= BG_COLOR;
            s2_sync <= s1_sync;
        end
    end

    assign bus.vga_color  = s2_color;
    assign bus.active_out = s2_sync.active;
    assign bus.hsync_out  = s2_sync.hsync;
    assign bus.vsync_out  = s2_sync.vsync;

`ifdef LAYER_COMPOSITOR_COLLIDE_EN
    logic [NUM_LAYERS-1:0] overlap;
    logic [NUM_LAYERS-1:0] acc;
    logic [NUM_LAYERS-1:0] mask;
    logic                  mask_valid;

    always_comb begin
        overlap = '0;
        if (bus.active_in) begin
            for (int i = 0; i < NUM_LAYERS; i++)
                overlap[i] = bus.layer_valid[i] & |(bus.layer_valid & ~(NUM_LAYERS'(1) << i));
        end
    end

    // The frame-end pixel's own overlap is folded into the latched mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            mask       <= '0;
            mask_valid <= 1'b0;
        end else begin
            mask_valid <= 1'b0;
            if (bus.pix_en) begin
                if (bus.frame_done_in) begin
                    mask       <= acc | overlap;
                    acc        <= '0;
                    mask_valid <= 1'b1;
                end else begin
                    acc <= acc | overlap;
                end
            end
        end
    end

    assign bus.collide_mask  = mask;
    assign bus.collide_valid = mask_valid;
`else
    logic unused_frame_done;
    assign unused_frame_done = bus.frame_done_in;

    assign bus.collide_mask  = '0;
    assign bus.collide_valid = 1'b0;
`endif

endmodule
